// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MemOP codes, response codes, FSM states
// and the opcode size decode.
package lsu_pkg;

    typedef enum logic [3:0] {
        OpSb  = 4'b0000,
        OpSh  = 4'b0001,
        OpSw  = 4'b0010,
        OpSd  = 4'b0011,
        OpLb  = 4'b0100,
        OpLh  = 4'b0101,
        OpLw  = 4'b0110,
        OpLbu = 4'b0111,
        OpLhu = 4'b1000,
        OpLwu = 4'b1001,
        OpLd  = 4'b1010
    } mem_op_e;

    typedef enum logic [2:0] {
        ErrOk         = 3'b000,
        ErrMisaligned = 3'b001,
        ErrIllegal    = 3'b010,
        ErrBus        = 3'b011,
        ErrTimeout    = 3'b100
    } rsp_err_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StResp = 2'b11
    } state_e;

    // Access size in bytes; 0 marks an undefined opcode.
    function automatic logic [3:0] op_size(input logic [3:0] op);
        case (op)
            OpSb, OpLb, OpLbu: op_size = 4'd1;
            OpSh, OpLh, OpLhu: op_size = 4'd2;
            OpSw, OpLw, OpLwu: op_size = 4'd4;
            OpSd, OpLd:        op_size = 4'd8;
            default:           op_size = 4'd0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        op_is_store = (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: byte enables, store data shift, load extraction and
// opcode legality / alignment checks.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned NB = XLEN / 8,
    localparam int unsigned OW = $clog2(NB)
) (
    input  logic [3:0]      op,
    input  logic [OW-1:0]   offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [NB-1:0]   be,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned,
    output logic            illegal
);

    logic [3:0]      size;
    logic [3:0]      off_w;
    logic [15:0]     mask;
    logic [XLEN-1:0] rsh;

    always_comb begin
        size       = op_size(op);
        off_w      = 4'(offset);
        illegal    = (size == 4'd0) || ((XLEN != 64) && ((size == 4'd8) || (op == OpLwu)));
        misaligned = |(off_w & (size - 4'd1));
        mask       = (16'd1 << size) - 16'd1;
        be         = NB'(mask) << offset;
        wdata_sh   = wdata << {offset, 3'b000};
        rsh        = rdata >> {offset, 3'b000};
        rdata_ext  = '0;
        // Size casts of signed operands sign-extend; unsigned operands zero-extend.
        case (op)
            OpLb:    rdata_ext = XLEN'($signed(rsh[7:0]));
            OpLh:    rdata_ext = XLEN'($signed(rsh[15:0]));
            OpLw:    rdata_ext = XLEN'($signed(rsh[31:0]));
            OpLbu:   rdata_ext = XLEN'(rsh[7:0]);
            OpLhu:   rdata_ext = XLEN'(rsh[15:0]);
            OpLwu:   rdata_ext = XLEN'(rsh[31:0]);
            OpLd:    rdata_ext = rsh;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Handshaked load/store unit: one operation at a time over a req/gnt/rvalid bus, with
// error reporting for illegal ops, misalignment, bus errors and timeouts.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [XLEN-1:0]   req_base,
    input  logic [XLEN-1:0]   req_imm,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [2:0]        rsp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    rsp_err_e        err_q, err_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q;
    logic [OW-1:0]   off_q;
    logic [XLEN-1:0] addr_q;
    logic [NB-1:0]   be_q;
    logic [XLEN-1:0] wdata_q;
    logic            we_q;
    logic            accept;
    logic            tmo;

    logic [XLEN-1:0] ea;
    logic [3:0]      op_sel;
    logic [OW-1:0]   off_sel;
    logic [NB-1:0]   a_be;
    logic [XLEN-1:0] a_wdata;
    logic [XLEN-1:0] a_rdata;
    logic            a_mis;
    logic            a_ill;

    assign ea = req_base + req_imm;
    // One aligner serves both directions: live request in IDLE, latched op afterwards.
    assign op_sel  = (state_q == StIdle) ? req_op : op_q;
    assign off_sel = (state_q == StIdle) ? ea[OW-1:0] : off_q;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .op        (op_sel),
        .offset    (off_sel),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (a_be),
        .wdata_sh  (a_wdata),
        .rdata_ext (a_rdata),
        .misaligned(a_mis),
        .illegal   (a_ill)
    );

    assign tmo = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (a_ill) begin
                        err_d   = ErrIllegal;
                        state_d = StResp;
                    end else if (a_mis) begin
                        err_d   = ErrMisaligned;
                        state_d = StResp;
                    end else begin
                        err_d   = ErrOk;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (tmo) begin
                    err_d   = ErrTimeout;
                    state_d = StResp;
                end else if (mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    state_d = StResp;
                    if (mem_err) err_d = ErrBus;
                    else rdata_d = a_rdata;
                end else if (tmo) begin
                    err_d   = ErrTimeout;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            err_q   <= ErrOk;
            rdata_q <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= req_op;
                off_q   <= ea[OW-1:0];
                addr_q  <= {ea[XLEN-1:OW], {OW{1'b0}}};
                be_q    <= a_be;
                wdata_q <= a_wdata;
                we_q    <= op_is_store(req_op);
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign mem_req   = (state_q == StReq);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule
